tick_counter: RTL and testbench
===============================

TICK_COUNTER -- requirements
Module: tick_counter

Interface
REQ-001 SHALL have parameter PERIOD, default 60: number of accepted ticks per elapsed-time report (legal 1..65535).
REQ-002 SHALL have parameter TIMEOUT, default 100000000: watchdog limit in clk cycles, used only under REQ-025.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port input_tick  input  16  tick stream data; value ignored.
REQ-006 SHALL have port input_tick_stb  input  1  upstream asserts when input_tick is valid.
REQ-007 SHALL have port input_tick_ack  output  1  block ready to accept a tick.
REQ-008 SHALL have port output_elapsed  output  16  running total of accepted ticks at report time.
REQ-009 SHALL have port output_elapsed_stb  output  1  output_elapsed valid.
REQ-010 SHALL have port output_elapsed_ack  input  1  downstream accepts output_elapsed.
REQ-011 SHALL have port timeout_err  output  1  watchdog error flag (constant 0 when REQ-025 is compiled out).

Function
REQ-012 SHALL implement FSM states RECV, ACCUM, SEND, plus WAIT_ERR under REQ-025; all outputs registered.
REQ-013 In RECV, input_tick_ack SHALL be 1; a transfer occurs on a cycle with input_tick_stb=1 and input_tick_ack=1; the next state is ACCUM.
REQ-014 In ACCUM, input_tick_ack SHALL be 0, so one stb pulse held until ack is never counted twice; this state lasts exactly 1 cycle.
REQ-015 In ACCUM, the block SHALL increment the 16-bit total by 1 with modulo-2^16 wrap (0xFFFF -> 0x0000) and increment the period counter.
REQ-016 When the incremented period counter equals PERIOD, the block SHALL clear the period counter, load output_elapsed with the new total, set output_elapsed_stb=1, and enter SEND; otherwise it SHALL return to RECV.
REQ-017 In SEND, output_elapsed and output_elapsed_stb=1 SHALL stay stable until a cycle with output_elapsed_ack=1; stb SHALL drop on the next edge and the FSM SHALL return to RECV.
REQ-018 In SEND, input_tick_ack SHALL be 0; upstream stalls by holding stb, and no tick is lost or double-counted.
REQ-019 Latency: from the tick transfer edge to output_elapsed_stb=1 SHALL be 2 cycles; input_tick_ack SHALL re-assert 1 cycle after a non-reporting tick transfer.
REQ-020 output_elapsed_ack asserted outside SEND SHALL be ignored.
REQ-021 With PERIOD=1, every accepted tick SHALL produce a report.

Reset
REQ-022 While rst=0, the block SHALL be in RECV with total=0, period counter=0, output_elapsed=0, output_elapsed_stb=0, timeout_err=0, and watchdog counter=0; input_tick_ack SHALL be 0 during reset.
REQ-023 input_tick_ack SHALL become 1 on the first clk edge after rst deasserts.
REQ-024 Reset asserted mid-SEND SHALL drop output_elapsed_stb immediately (asynchronous) and discard the pending report.

Configuration
REQ-025 Macro TICK_WATCHDOG_EN, when defined:
- A watchdog counter SHALL count cycles spent in RECV without a transfer, and clear on each transfer.
- On reaching TIMEOUT, timeout_err SHALL set and the FSM SHALL enter WAIT_ERR.
- In WAIT_ERR, input_tick_ack SHALL be 1; the next transfer SHALL clear timeout_err, count normally, and proceed as ACCUM.
- The counter SHALL not run in ACCUM or SEND.
REQ-026 When TICK_WATCHDOG_EN is undefined, the block SHALL have no watchdog logic, no WAIT_ERR state, and timeout_err tied to 0.

Structure
REQ-027 A shared package speedometer_pkg SHALL hold the FSM state encoding, the stream data width (16), and default PERIOD/TIMEOUT constants.
REQ-028 The block SHALL be single-level except for one sub-module, stream_out_reg: a holding register with stb/ack logic for the output stream.

Verification
REQ-029 PERIOD=3; rst low then high; 3 ticks, each stb held until ack -> one report, output_elapsed=3, stb 2 cycles after the third transfer.
REQ-030 PERIOD=3; input_tick_stb tied high continuously -> exactly 1 count per 2 cycles; reports of 3, 6, 9.
REQ-031 PERIOD=3; output_elapsed_ack held low 20 cycles during SEND -> output_elapsed_stb and value stable; input_tick_ack=0 throughout; no ticks counted until ack.
REQ-032 PERIOD=1; total preloaded by 65535 ticks; one more tick -> output_elapsed=0x0000 (wrap).
REQ-033 With TICK_WATCHDOG_EN, TIMEOUT=10; no stb for 12 cycles -> timeout_err=1 at the 10th idle cycle; next tick -> timeout_err=0 and total increments.
REQ-034 rst pulsed low during SEND -> output_elapsed_stb=0 immediately; after release, next report is based on total restarting from 0.

Source files
------------

// File: rtl/speedometer_pkg.sv
// Shared constants and FSM encoding for the tick counter (speedometer) blocks.
// The WAIT_ERR state exists only when TICK_WATCHDOG_EN is defined.
package speedometer_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned DEFAULT_PERIOD  = 60;
    localparam int unsigned DEFAULT_TIMEOUT = 100000000;
    localparam int unsigned WD_W            = 32;

`ifdef TICK_WATCHDOG_EN
    typedef enum logic [1:0] {
        ST_RECV     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_SEND     = 2'd2,
        ST_WAIT_ERR = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SEND  = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register: data and stb stay stable from load until the
// downstream ack is seen.
module stream_out_reg
    import speedometer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data,
    output logic              stb,
    input  logic              ack,
    output logic              done_c
);

    // load only ever arrives while stb is low, so it never races a handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            stb  <= 1'b0;
        end else if (load) begin
            data <= load_data;
            stb  <= 1'b1;
        end else if (stb && ack) begin
            stb  <= 1'b0;
        end
    end

    assign done_c = stb & ack;

endmodule

// File: rtl/tick_counter.sv
// Counts accepted ticks and reports the running total every PERIOD ticks.
// Optional watchdog on idle RECV time is enabled by defining TICK_WATCHDOG_EN.
module tick_counter
    import speedometer_pkg::*;
#(
    parameter int unsigned PERIOD  = DEFAULT_PERIOD,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] input_tick,
    input  logic              input_tick_stb,
    output logic              input_tick_ack,
    output logic [DATA_W-1:0] output_elapsed,
    output logic              output_elapsed_stb,
    input  logic              output_elapsed_ack,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = DATA_W + 1;

    if (PERIOD == 0 || PERIOD > 65535) begin : g_bad_period
        $error("tick_counter: PERIOD must be in 1..65535");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("tick_counter: TIMEOUT must be at least 1");
    end

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   total_q, total_d;
    logic [DATA_W-1:0]   period_q, period_d;
    logic                ack_q, ack_d;
    logic                load_q, load_d;
    logic [CNT_W-1:0]    period_inc_c;
    logic                xfer_c;
    logic                done_c;
    logic                unused_tick_c;
`ifdef TICK_WATCHDOG_EN
    logic                err_q, err_d;
    logic [WD_W-1:0]     wd_q, wd_d;
`endif

    assign unused_tick_c = ^input_tick;
    assign xfer_c        = input_tick_stb & ack_q;
    assign period_inc_c  = CNT_W'(period_q) + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        period_d = period_q;
        ack_d    = ack_q;
        load_d   = 1'b0;
`ifdef TICK_WATCHDOG_EN
        err_d    = err_q;
        wd_d     = wd_q;
`endif
        case (state_q)
            ST_RECV: begin
                if (xfer_c) begin
                    state_d = ST_ACCUM;
                    ack_d   = 1'b0;
`ifdef TICK_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    ack_d   = 1'b1;
`ifdef TICK_WATCHDOG_EN
                    if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        wd_d    = '0;
                        err_d   = 1'b1;
                        state_d = ST_WAIT_ERR;
                    end else begin
                        wd_d    = wd_q + WD_W'(1);
                    end
`endif
                end
            end
            ST_ACCUM: begin
                total_d = total_q + DATA_W'(1);
                if (period_inc_c == CNT_W'(PERIOD)) begin
                    period_d = '0;
                    load_d   = 1'b1;
                    state_d  = ST_SEND;
                    ack_d    = 1'b0;
                end else begin
                    period_d = period_inc_c[DATA_W-1:0];
                    state_d  = ST_RECV;
                    ack_d    = 1'b1;
                end
            end
            ST_SEND: begin
                if (done_c) begin
                    state_d = ST_RECV;
                    ack_d   = 1'b1;
                end else begin
                    ack_d   = 1'b0;
                end
            end
`ifdef TICK_WATCHDOG_EN
            ST_WAIT_ERR: begin
                ack_d = 1'b1;
                if (xfer_c) begin
                    err_d   = 1'b0;
                    wd_d    = '0;
                    state_d = ST_ACCUM;
                    ack_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_RECV;
                ack_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RECV;
            total_q  <= '0;
            period_q <= '0;
            ack_q    <= 1'b0;
            load_q   <= 1'b0;
`ifdef TICK_WATCHDOG_EN
            err_q    <= 1'b0;
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            period_q <= period_d;
            ack_q    <= ack_d;
            load_q   <= load_d;
`ifdef TICK_WATCHDOG_EN
            err_q    <= err_d;
            wd_q     <= wd_d;
`endif
        end
    end

    // load_q fires one cycle after ACCUM, when total_q already holds the new count
    stream_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load_q),
        .load_data (total_q),
        .data      (output_elapsed),
        .stb       (output_elapsed_stb),
        .ack       (output_elapsed_ack),
        .done_c    (done_c)
    );

    assign input_tick_ack = ack_q;

`ifdef TICK_WATCHDOG_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter: a per-cycle vector table for the streaming
// case plus hand-written sequences for stall, async reset, wrap and watchdog.
module tb_tick_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tick_a, tick_b;
    logic        stb_a, ack_a, ostb_a, oack_a, err_a;
    logic        stb_b, ack_b, ostb_b, oack_b, err_b;
    logic [15:0] el_a, el_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tick_counter #(.PERIOD(3), .TIMEOUT(10)) dut_a (
        .clk                (clk),
        .rst                (rst),
        .input_tick         (tick_a),
        .input_tick_stb     (stb_a),
        .input_tick_ack     (ack_a),
        .output_elapsed     (el_a),
        .output_elapsed_stb (ostb_a),
        .output_elapsed_ack (oack_a),
        .timeout_err        (err_a)
    );

    tick_counter #(.PERIOD(1), .TIMEOUT(10)) dut_b (
        .clk                (clk),
        .rst                (rst),
        .input_tick         (tick_b),
        .input_tick_stb     (stb_b),
        .input_tick_ack     (ack_b),
        .output_elapsed     (el_b),
        .output_elapsed_stb (ostb_b),
        .output_elapsed_ack (oack_b),
        .timeout_err        (err_b)
    );

    typedef struct {
        logic        stb;
        logic        oack;
        logic        iack;
        logic        ostb;
        logic [15:0] el;
    } vec_t;

    vec_t vt[25];

    function automatic vec_t mk(input logic iack, input logic ostb, input logic [15:0] el);
        vec_t v;
        v.stb  = 1'b1;
        v.oack = 1'b1;
        v.iack = iack;
        v.ostb = ostb;
        v.el   = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stb_a  = 1'b0;
        stb_b  = 1'b0;
        oack_a = 1'b0;
        oack_b = 1'b0;
        rst    = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    // Hold stb until a transfer edge; returns just after that edge
    task automatic send_tick(input bit on_b);
        bit seen_ack;
        bit done;
        done = 1'b0;
        if (on_b) stb_b = 1'b1; else stb_a = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            seen_ack = on_b ? ack_b : ack_a;
            step();
            done = seen_ack;
        end
        if (on_b) stb_b = 1'b0; else stb_a = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL tick_xfer: got ack=0 for 50 cycles, expected a transfer");
        end
    endtask

    initial begin
        tick_a = 16'h1234;
        tick_b = 16'hBEEF;
        stb_a  = 1'b0;
        stb_b  = 1'b0;
        oack_a = 1'b0;
        oack_b = 1'b0;
        rst    = 1'b0;

        // Streaming with stb and ack tied high: 1 count per 2 cycles, reports 3, 6, 9
        vt = '{mk(1,0,16'd0), mk(0,0,16'd0), mk(1,0,16'd0), mk(0,0,16'd0), mk(1,0,16'd0),
               mk(0,0,16'd0), mk(0,0,16'd0), mk(0,1,16'd3), mk(1,0,16'd3), mk(0,0,16'd3),
               mk(1,0,16'd3), mk(0,0,16'd3), mk(1,0,16'd3), mk(0,0,16'd3), mk(0,0,16'd3),
               mk(0,1,16'd6), mk(1,0,16'd6), mk(0,0,16'd6), mk(1,0,16'd6), mk(0,0,16'd6),
               mk(1,0,16'd6), mk(0,0,16'd6), mk(0,0,16'd6), mk(0,1,16'd9), mk(1,0,16'd9)};

        repeat (2) step();
        check("rst_iack", 16'(ack_a), 16'd0);
        check("rst_ostb", 16'(ostb_a), 16'd0);
        check("rst_el",   el_a, 16'd0);
        check("rst_err",  16'(err_a), 16'd0);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            stb_a  = vt[i].stb;
            oack_a = vt[i].oack;
            step();
            check($sformatf("vec%0d_iack", i), 16'(ack_a), 16'(vt[i].iack));
            check($sformatf("vec%0d_ostb", i), 16'(ostb_a), 16'(vt[i].ostb));
            check($sformatf("vec%0d_el", i),   el_a, vt[i].el);
        end

        // Three handshaken ticks, then a 20-cycle downstream stall
        do_reset();
        repeat (3) send_tick(1'b0);
        step();
        check("lat1_ostb", 16'(ostb_a), 16'd0);
        step();
        check("lat2_ostb", 16'(ostb_a), 16'd1);
        check("lat2_el",   el_a, 16'd3);
        stb_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_ostb", 16'(ostb_a), 16'd1);
            check("stall_el",   el_a, 16'd3);
            check("stall_iack", 16'(ack_a), 16'd0);
        end
        oack_a = 1'b1;
        step();
        check("ackd_ostb", 16'(ostb_a), 16'd0);
        check("ackd_iack", 16'(ack_a), 16'd1);
        oack_a = 1'b0;
        repeat (3) send_tick(1'b0);
        repeat (2) step();
        check("rpt6_ostb", 16'(ostb_a), 16'd1);
        check("rpt6_el",   el_a, 16'd6);

        // Asynchronous reset while a report is pending
        #3;
        rst = 1'b0;
        #1;
        check("arst_ostb", 16'(ostb_a), 16'd0);
        check("arst_el",   el_a, 16'd0);
        check("arst_iack", 16'(ack_a), 16'd0);
        step();
        rst = 1'b1;
        oack_a = 1'b1;
        repeat (3) send_tick(1'b0);
        repeat (2) step();
        check("post_rst_ostb", 16'(ostb_a), 16'd1);
        check("post_rst_el",   el_a, 16'd3);
        step();
        check("post_rst_drop", 16'(ostb_a), 16'd0);

`ifdef TICK_WATCHDOG_EN
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("wd_idle%0d", i + 1), 16'(err_a), 16'd0);
        end
        step();
        check("wd_trip", 16'(err_a), 16'd1);
        repeat (2) step();
        check("wd_hold", 16'(err_a), 16'd1);
        check("wd_iack", 16'(ack_a), 16'd1);
        oack_a = 1'b1;
        send_tick(1'b0);
        check("wd_clear", 16'(err_a), 16'd0);
        repeat (2) send_tick(1'b0);
        repeat (2) step();
        check("wd_rpt_el", el_a, 16'd3);
`else
        repeat (12) step();
        check("no_wd_err", 16'(err_a), 16'd0);
`endif

        // PERIOD=1 wrap: preload the total just below 0xFFFF
        force dut_b.total_q = 16'hFFFD;
        step();
        release dut_b.total_q;
        oack_b = 1'b1;
        send_tick(1'b1);
        repeat (2) step();
        check("p1_ostb_a", 16'(ostb_b), 16'd1);
        check("p1_el_a",   el_b, 16'hFFFE);
        send_tick(1'b1);
        repeat (2) step();
        check("p1_ostb_b", 16'(ostb_b), 16'd1);
        check("p1_el_b",   el_b, 16'hFFFF);
        send_tick(1'b1);
        repeat (2) step();
        check("wrap_ostb", 16'(ostb_b), 16'd1);
        check("wrap_el",   el_b, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
